// File: rtl/euler_pkg.sv
// Shared types and constants for the Euler solver-bank scheduler.
package euler_pkg;

   localparam int SUM_W = 32;
   localparam int CYC_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK  = 2'd0,
      ERR_IDX = 2'd1,
      ERR_TMO = 2'd2
   } err_e;

endpackage

// File: rtl/euler_core_mux.sv
// Combinational core selection: picks the addressed core's IsEnd/sum and
// produces the one-hot Init decode. Out-of-range indices select nothing.
module euler_core_mux
   import euler_pkg::*;
#(
   parameter int N_CORES = 4,
   parameter int IDX_W   = 2
) (
   input  logic [IDX_W-1:0]         idx_i,
   input  logic [N_CORES-1:0]       core_end_i,
   input  logic [SUM_W*N_CORES-1:0] core_sum_i,
   output logic                     end_o,
   output logic [SUM_W-1:0]         sum_o,
   output logic [N_CORES-1:0]       onehot_o
);

   logic [SUM_W-1:0] sum_masked [N_CORES];

   for (genvar gi = 0; gi < N_CORES; gi++) begin : g_sel
      assign onehot_o[gi]   = (idx_i == IDX_W'(gi));
      assign sum_masked[gi] = onehot_o[gi] ? core_sum_i[SUM_W*gi +: SUM_W] : '0;
   end

   assign end_o = |(onehot_o & core_end_i);

   // Masked OR-tree: at most one term is non-zero.
   always_comb begin
      sum_o = '0;
      for (int k = 0; k < N_CORES; k++) begin
         sum_o = sum_o | sum_masked[k];
      end
   end

endmodule

// File: rtl/euler_sched.sv
// Job sequencer for a bank of Euler solver cores: launch, wait for IsEnd, report.
// Optional run watchdog enabled by defining EULER_SCHED_TIMEOUT_EN.
module euler_sched
   import euler_pkg::*;
#(
   parameter int N_CORES     = 4,
   parameter int IDX_W       = 2,
   parameter int INIT_CYCLES = 2,
   parameter int TIMEOUT     = 1048576
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     ReqValid,
   input  logic [IDX_W-1:0]         ReqIdx,
   output logic                     ReqReady,
   output logic [N_CORES-1:0]       CoreInit,
   input  logic [N_CORES-1:0]       CoreEnd,
   input  logic [SUM_W*N_CORES-1:0] CoreSum,
   output logic                     RspValid,
   input  logic                     RspReady,
   output logic [SUM_W-1:0]         RspData,
   output logic [IDX_W-1:0]         RspIdx,
   output logic [CYC_W-1:0]         RspCycles,
   output logic [1:0]               RspErr,
   output logic                     Busy
);

   localparam int                LCNT_W    = $clog2(INIT_CYCLES + 1);
   localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(INIT_CYCLES);
   localparam logic [CYC_W-1:0]  CYC_MAX   = '1;
   localparam logic [CYC_W-1:0]  TMO_LIMIT = CYC_W'(TIMEOUT);
`ifdef EULER_SCHED_TIMEOUT_EN
   localparam bit                TMO_EN    = 1'b1;
`else
   localparam bit                TMO_EN    = 1'b0;
`endif

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
   logic [N_CORES-1:0] init_q, init_d;
   logic [CYC_W-1:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]   data_q, data_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   err_e               err_q, err_d;

   logic               sel_end;
   logic [SUM_W-1:0]   sel_sum;
   logic [N_CORES-1:0] sel_onehot;
   logic               bad_idx;
   logic               tmo_hit;

   euler_core_mux #(
      .N_CORES (N_CORES),
      .IDX_W   (IDX_W)
   ) u_mux (
      .idx_i      (idx_q),
      .core_end_i (CoreEnd),
      .core_sum_i (CoreSum),
      .end_o      (sel_end),
      .sum_o      (sel_sum),
      .onehot_o   (sel_onehot)
   );

   assign bad_idx = (32'(ReqIdx) >= 32'(N_CORES));
   assign tmo_hit = TMO_EN && (cnt_q == TMO_LIMIT);

   // State and datapath registers; reset also drops CoreInit immediately.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lcnt_q  <= '0;
         init_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         cyc_q   <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lcnt_q  <= lcnt_d;
         init_q  <= init_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lcnt_d  = lcnt_q;
      init_d  = init_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      cyc_d   = cyc_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (ReqValid) begin
               idx_d = ReqIdx;
               if (bad_idx) begin
                  state_d = RESP;
                  data_d  = '0;
                  cyc_d   = '0;
                  err_d   = ERR_IDX;
               end else begin
                  state_d = LAUNCH;
                  lcnt_d  = '0;
               end
            end
         end
         // Init goes high on the first LAUNCH edge and stays for INIT_CYCLES cycles.
         LAUNCH: begin
            if (lcnt_q == LCNT_LAST) begin
               state_d = RUN;
               init_d  = '0;
               cnt_d   = CYC_W'(1);
            end else begin
               init_d  = sel_onehot;
               lcnt_d  = lcnt_q + LCNT_W'(1);
            end
         end
         RUN: begin
            cnt_d = (cnt_q == CYC_MAX) ? cnt_q : cnt_q + CYC_W'(1);
            if (sel_end) begin
               state_d = RESP;
               data_d  = sel_sum;
               cyc_d   = cnt_q;
               err_d   = ERR_OK;
            end else if (tmo_hit) begin
               state_d = RESP;
               data_d  = '0;
               cyc_d   = TMO_LIMIT;
               err_d   = ERR_TMO;
            end
         end
         RESP: begin
            if (RspReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ReqReady = (state_q == IDLE);
      Busy     = (state_q != IDLE);
      RspValid = (state_q == RESP);
   end

   assign CoreInit  = init_q;
   assign RspData   = data_q;
   assign RspIdx    = idx_q;
   assign RspCycles = cyc_q;
   assign RspErr    = err_q;

endmodule

// File: tb/tb_euler_sched.sv
// Scoreboard bench for euler_sched: directed jobs on modelled cores, monitor checks responses.
`timescale 1ns/1ps
module tb_euler_sched;

   localparam int N_CORES     = 4;
   localparam int IDX_W       = 3;
   localparam int INIT_CYCLES = 2;
   localparam int TIMEOUT     = 64;
   localparam int CYC1        = 10;
   localparam int CYC3        = 5;

   logic                  CLK = 1'b0;
   logic                  RST_N = 1'b0;
   logic                  ReqValid = 1'b0;
   logic [IDX_W-1:0]      ReqIdx = '0;
   logic                  ReqReady;
   logic [N_CORES-1:0]    CoreInit;
   logic [N_CORES-1:0]    CoreEnd;
   logic [32*N_CORES-1:0] CoreSum;
   logic                  RspValid;
   logic                  RspReady = 1'b1;
   logic [31:0]           RspData;
   logic [IDX_W-1:0]      RspIdx;
   logic [31:0]           RspCycles;
   logic [1:0]            RspErr;
   logic                  Busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   euler_sched #(
      .N_CORES     (N_CORES),
      .IDX_W       (IDX_W),
      .INIT_CYCLES (INIT_CYCLES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .ReqValid  (ReqValid),
      .ReqIdx    (ReqIdx),
      .ReqReady  (ReqReady),
      .CoreInit  (CoreInit),
      .CoreEnd   (CoreEnd),
      .CoreSum   (CoreSum),
      .RspValid  (RspValid),
      .RspReady  (RspReady),
      .RspData   (RspData),
      .RspIdx    (RspIdx),
      .RspCycles (RspCycles),
      .RspErr    (RspErr),
      .Busy      (Busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Core models. Core 0: p1 (multiples of 3 or 5 below 1000). Cores 1/3: IsEnd
   // seen in RUN cycle CYC1/CYC3, held until next Init. Core 2 never ends.
   logic [N_CORES-1:0] end_r = '0;
   logic [31:0]        acc0 = '0;
   int unsigned        p1_i = 0;
   bit                 p1_run = 1'b0;
   int unsigned        t1 = 0, t3 = 0;
   bit                 run1 = 1'b0, run3 = 1'b0;

   always @(posedge CLK) begin
      if (CoreInit[0]) begin
         p1_i <= 1; acc0 <= '0; p1_run <= 1'b1; end_r[0] <= 1'b0;
      end else if (p1_run) begin
         if (p1_i < 1000) begin
            if (p1_i % 3 == 0 || p1_i % 5 == 0) acc0 <= acc0 + p1_i;
            p1_i <= p1_i + 1;
         end else begin
            end_r[0] <= 1'b1; p1_run <= 1'b0;
         end
      end
      if (CoreInit[1]) begin
         t1 <= 0; run1 <= 1'b1; end_r[1] <= 1'b0;
      end else if (run1) begin
         t1 <= t1 + 1;
         if (t1 + 2 == CYC1) begin end_r[1] <= 1'b1; run1 <= 1'b0; end
      end
      if (CoreInit[3]) begin
         t3 <= 0; run3 <= 1'b1; end_r[3] <= 1'b0;
      end else if (run3) begin
         t3 <= t3 + 1;
         if (t3 + 2 == CYC3) begin end_r[3] <= 1'b1; run3 <= 1'b0; end
      end
   end

   assign CoreEnd = end_r;
   assign CoreSum = {32'h12345678, 32'h0BADF00D, 32'hDEADBEEF, acc0};

   typedef struct {
      logic [31:0]      data;
      logic [IDX_W-1:0] idx;
      logic [31:0]      cycles;
      logic [1:0]       err;
      bit               chk_cyc;
      int               lat;
      int               hs;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t mk(input logic [31:0] data, input int idx, input logic [31:0] cycles,
                               input logic [1:0] err, input bit chk_cyc, input int lat);
      exp_t e;
      e.data = data; e.idx = idx[IDX_W-1:0]; e.cycles = cycles; e.err = err;
      e.chk_cyc = chk_cyc; e.lat = lat; e.hs = 0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: latency measured from the handshake edge to the edge raising RspValid.
   int   rise_cyc = 0;
   logic vprev = 1'b0;
   bit   init_seen = 1'b0;

   always @(negedge CLK) begin : mon
      exp_t e;
      if (CoreInit != '0) init_seen = 1'b1;
      if ($countones(CoreInit) > 1) chk("init_onehot", 32'(CoreInit), 32'd0);
      if (RspValid && !vprev) rise_cyc = cyc;
      vprev = RspValid;
      if (RspValid && RspReady) begin
         $display("rsp idx=%0d data=0x%08h cycles=%0d err=%0d", RspIdx, RspData, RspCycles, RspErr);
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", RspData, e.data);
            chk("rsp_idx", 32'(RspIdx), 32'(e.idx));
            chk("rsp_err", 32'(RspErr), 32'(e.err));
            if (e.chk_cyc) chk("rsp_cycles", RspCycles, e.cycles);
            if (e.lat >= 0) chk("rsp_latency", 32'(rise_cyc - e.hs), 32'(e.lat));
         end
      end
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic issue(input int idx, input bit push, input exp_t e);
      int n = 0;
      while (!ReqReady && n < 3000) begin step(); n++; end
      if (!ReqReady) chk("req_ready_timeout", 32'd0, 32'd1);
      ReqValid = 1'b1;
      ReqIdx   = idx[IDX_W-1:0];
      step();
      ReqValid = 1'b0;
      e.hs = cyc;
      $display("req idx=%0d at cycle %0d", idx, cyc);
      if (push) sb.push_back(e);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin step(); n++; end
      chk(nm, 32'(sb.size()), 32'd0);
      sb.delete();
      step();
   endtask

   task automatic pulse_reset(input string nm);
      RST_N = 1'b0;
      #1;
      chk({nm, "_init_low"}, 32'(CoreInit), 32'd0);
      chk({nm, "_valid_low"}, 32'(RspValid), 32'd0);
      chk({nm, "_busy_low"}, 32'(Busy), 32'd0);
      step();
      RST_N = 1'b1;
      step();
      chk({nm, "_ready_after"}, 32'(ReqReady), 32'd1);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin : stim
      int n;
      step(); step();
      chk("rst_valid", 32'(RspValid), 32'd0);
      chk("rst_data", RspData, 32'd0);
      chk("rst_idx", 32'(RspIdx), 32'd0);
      chk("rst_cycles", RspCycles, 32'd0);
      chk("rst_err", 32'(RspErr), 32'd0);
      chk("rst_init", 32'(CoreInit), 32'd0);
      chk("rst_ready", 32'(ReqReady), 32'd1);
      chk("rst_busy", 32'(Busy), 32'd0);
      RST_N = 1'b1;
      step();

      issue(0, 1'b1, mk(32'd233168, 0, 32'd0, 2'd0, 1'b0, -1));
      drain("p1_drain");

      issue(1, 1'b1, mk(32'hDEADBEEF, 1, 32'd10, 2'd0, 1'b1, 13));
      drain("core1_drain");

      // Core 1 keeps IsEnd high throughout; must be ignored.
      issue(3, 1'b1, mk(32'h12345678, 3, 32'd5, 2'd0, 1'b1, 8));
      drain("core3_drain");

      // Bad index: valid already high in the cycle right after the handshake.
      init_seen = 1'b0;
      issue(5, 1'b1, mk(32'd0, 5, 32'd0, 2'd1, 1'b1, 0));
      chk("badidx_valid_next", 32'(RspValid), 32'd1);
      drain("badidx_drain");
      chk("badidx_no_init", 32'(init_seen), 32'd0);

      // Stall the response channel for 20 cycles.
      RspReady = 1'b0;
      issue(1, 1'b1, mk(32'hDEADBEEF, 1, 32'd10, 2'd0, 1'b1, 13));
      n = 0;
      while (!RspValid && n < 100) begin step(); n++; end
      chk("stall_valid_rise", 32'(RspValid), 32'd1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("stall_valid", 32'(RspValid), 32'd1);
         chk("stall_data", RspData, 32'hDEADBEEF);
         chk("stall_req_ready", 32'(ReqReady), 32'd0);
      end
      RspReady = 1'b1;
      step();
      chk("stall_released_ready", 32'(ReqReady), 32'd1);
      issue(3, 1'b1, mk(32'h12345678, 3, 32'd5, 2'd0, 1'b1, 8));
      drain("b2b_drain");

      // Reset while Init is being driven.
      issue(1, 1'b0, mk(32'd0, 1, 32'd0, 2'd0, 1'b0, -1));
      step();
      chk("launch_init_onehot", 32'(CoreInit), 32'h2);
      pulse_reset("rst_launch");

      // Reset during RUN on a core that never finishes.
      issue(2, 1'b0, mk(32'd0, 2, 32'd0, 2'd0, 1'b0, -1));
      repeat (30) step();
      chk("run_busy", 32'(Busy), 32'd1);
      chk("run_no_valid", 32'(RspValid), 32'd0);
      pulse_reset("rst_run");
      repeat (5) step();
      chk("rst_run_no_stray", 32'(RspValid), 32'd0);

`ifdef EULER_SCHED_TIMEOUT_EN
      issue(2, 1'b1, mk(32'd0, 2, 32'd64, 2'd2, 1'b1, 67));
      drain("timeout_drain");
`else
      issue(2, 1'b0, mk(32'd0, 2, 32'd0, 2'd0, 1'b0, -1));
      repeat (1000) step();
      chk("hang_busy", 32'(Busy), 32'd1);
      chk("hang_no_valid", 32'(RspValid), 32'd0);
      pulse_reset("rst_hang");
`endif

      issue(3, 1'b1, mk(32'h12345678, 3, 32'd5, 2'd0, 1'b1, 8));
      drain("recover_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
